// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the WB stage / MD unit and the register-file write arbiter.
// Optional pending-hit query ports appear when WBA_PENDING_CHECK_EN is defined.
interface wb_write_arbiter_if;
    logic        WB_RegWrite_In;
    logic [4:0]  WB_WriteReg_In;
    logic [31:0] WB_Data_In;
    logic        MD_Valid_In;
    logic [4:0]  MD_WriteReg_In;
    logic [31:0] MD_Data_In;
    logic        MD_Ready_Out;
    logic        RF_WriteEn_Out;
    logic [4:0]  RF_WriteReg_Out;
    logic [31:0] RF_WriteData_Out;
    logic        Stall_Out;
`ifdef WBA_PENDING_CHECK_EN
    logic [4:0]  Query_Reg_In;
    logic        Pending_Hit_Out;
`endif

    modport slave (
        input  WB_RegWrite_In, WB_WriteReg_In, WB_Data_In,
        input  MD_Valid_In, MD_WriteReg_In, MD_Data_In,
`ifdef WBA_PENDING_CHECK_EN
        input  Query_Reg_In,
        output Pending_Hit_Out,
`endif
        output MD_Ready_Out, RF_WriteEn_Out, RF_WriteReg_Out, RF_WriteData_Out, Stall_Out
    );

    modport master (
        output WB_RegWrite_In, WB_WriteReg_In, WB_Data_In,
        output MD_Valid_In, MD_WriteReg_In, MD_Data_In,
`ifdef WBA_PENDING_CHECK_EN
        output Query_Reg_In,
        input  Pending_Hit_Out,
`endif
        input  MD_Ready_Out, RF_WriteEn_Out, RF_WriteReg_Out, RF_WriteData_Out, Stall_Out
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB wins, MD results queue and drain into idle slots,
// starvation guard forces a one-cycle stall. Optional macro: WBA_PENDING_CHECK_EN.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    wb_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_CNT   = (AW+1)'(1'b0);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1'b1);
    localparam logic [SW-1:0] STARVE_CLR = SW'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [4:0]    mem_reg_q  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic          rf_en_q, rf_en_d;
    logic [4:0]    rf_reg_q, rf_reg_d;
    logic [31:0]   rf_data_q, rf_data_d;
    logic          ready_s, stall_s, nonempty_s, wb_live_s, push_s, pop_s;

    assign ready_s    = (count_q != FULL_CNT);
    assign stall_s    = (state_q == ST_FORCE);
    assign nonempty_s = (count_q != ZERO_CNT);
    assign wb_live_s  = bus.WB_RegWrite_In && (bus.WB_WriteReg_In != 5'd0) && !stall_s;
    assign push_s     = bus.MD_Valid_In && ready_s;
    // During FORCE wb_live_s is already low, so the head is always popped.
    assign pop_s      = nonempty_s && !wb_live_s;

    assign bus.MD_Ready_Out     = ready_s;
    assign bus.Stall_Out        = stall_s;
    assign bus.RF_WriteEn_Out   = rf_en_q;
    assign bus.RF_WriteReg_Out  = rf_reg_q;
    assign bus.RF_WriteData_Out = rf_data_q;

    // Grant selection, FIFO bookkeeping and starvation state machine.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rf_en_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;

        if (wb_live_s) begin
            rf_en_d   = 1'b1;
            rf_reg_d  = bus.WB_WriteReg_In;
            rf_data_d = bus.WB_Data_In;
        end else if (pop_s) begin
            rf_en_d   = (mem_reg_q[rd_ptr_q] != 5'd0);
            rf_reg_d  = mem_reg_q[rd_ptr_q];
            rf_data_d = mem_data_q[rd_ptr_q];
        end else begin
            rf_en_d   = 1'b0;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        case (state_q)
            ST_IDLE: begin
                starve_d = STARVE_CLR;
                if (count_d != ZERO_CNT) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (pop_s) begin
                    starve_d = STARVE_CLR;
                end else begin
                    starve_d = starve_q + STARVE_ONE;
                end
                if (count_d == ZERO_CNT) begin
                    state_d  = ST_IDLE;
                    starve_d = STARVE_CLR;
                end else if (starve_d == STARVE_MAX) begin
                    state_d  = ST_FORCE;
                end else begin
                    state_d  = ST_WAIT;
                end
            end
            ST_FORCE: begin
                starve_d = STARVE_CLR;
                if (count_d != ZERO_CNT) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                starve_d = STARVE_CLR;
            end
        endcase
    end

    // State, pointers, counters and registered write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            starve_q  <= STARVE_CLR;
            count_q   <= ZERO_CNT;
            rd_ptr_q  <= {AW{1'b0}};
            wr_ptr_q  <= {AW{1'b0}};
            rf_en_q   <= 1'b0;
            rf_reg_q  <= 5'd0;
            rf_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rf_en_q   <= rf_en_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg_q[i]  <= 5'd0;
                mem_data_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_reg_q[wr_ptr_q]  <= bus.MD_WriteReg_In;
            mem_data_q[wr_ptr_q] <= bus.MD_Data_In;
        end else begin
            mem_reg_q[wr_ptr_q]  <= mem_reg_q[wr_ptr_q];
            mem_data_q[wr_ptr_q] <= mem_data_q[wr_ptr_q];
        end
    end

`ifdef WBA_PENDING_CHECK_EN
    logic pending_s;

    // Entry i is valid when its distance from the read pointer is below the count.
    always_comb begin
        pending_s = push_s && (bus.MD_WriteReg_In == bus.Query_Reg_In);
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - rd_ptr_q} < count_q) && (mem_reg_q[i] == bus.Query_Reg_In)) begin
                pending_s = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        if (bus.Query_Reg_In == 5'd0) begin
            pending_s = 1'b0;
        end else begin
            pending_s = pending_s;
        end
    end

    assign bus.Pending_Hit_Out = pending_s;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_write_arbiter_if bus();
    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending MD results and how long the head has gone unserved.
    logic [4:0]  q_reg[$];
    logic [31:0] q_data[$];
    int          head_wait;
    logic        exp_stall, exp_ready, exp_en, exp_pend;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bus.WB_RegWrite_In = we;
        bus.WB_WriteReg_In = wr;
        bus.WB_Data_In     = wd;
        bus.MD_Valid_In    = mv;
        bus.MD_WriteReg_In = mr;
        bus.MD_Data_In     = md;
`ifdef WBA_PENDING_CHECK_EN
        bus.Query_Reg_In   = 5'd0;
`endif
    endtask

    task automatic model_clear();
        q_reg.delete();
        q_data.delete();
        head_wait = 0;
    endtask

    // One cycle of the arbitration rules, applied to the inputs currently on the bus.
    task automatic model_eval();
        logic live, had, popped;
        exp_stall = (q_reg.size() > 0) && (head_wait >= STARVE_LIMIT);
        exp_ready = (q_reg.size() < DEPTH);
        exp_pend  = 1'b0;
`ifdef WBA_PENDING_CHECK_EN
        if (bus.Query_Reg_In != 5'd0) begin
            foreach (q_reg[k]) if (q_reg[k] == bus.Query_Reg_In) exp_pend = 1'b1;
            if (bus.MD_Valid_In && exp_ready && bus.MD_WriteReg_In == bus.Query_Reg_In) exp_pend = 1'b1;
        end
`endif
        live   = bus.WB_RegWrite_In && (bus.WB_WriteReg_In != 5'd0) && !exp_stall;
        had    = (q_reg.size() > 0);
        popped = 1'b0;
        if (live) begin
            exp_en = 1'b1; exp_reg = bus.WB_WriteReg_In; exp_data = bus.WB_Data_In;
        end else if (had) begin
            exp_reg = q_reg.pop_front(); exp_data = q_data.pop_front();
            exp_en  = (exp_reg != 5'd0);
            popped  = 1'b1;
        end else begin
            exp_en = 1'b0;
        end
        if (bus.MD_Valid_In && exp_ready) begin
            q_reg.push_back(bus.MD_WriteReg_In);
            q_data.push_back(bus.MD_Data_In);
        end
        head_wait = popped ? 0 : (had ? head_wait + 1 : 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, bus.Stall_Out, bus.MD_Ready_Out}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_vals got en=%b reg=%0d data=%h stall=%b ready=%b exp 0/0/0/0/1",
                     bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, bus.Stall_Out, bus.MD_Ready_Out);
        end
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== 2'b01) begin
                errors++;
                $display("FAIL reset_idle i=%0d got stall=%b ready=%b exp 0/1", i, bus.Stall_Out, bus.MD_Ready_Out);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_en i=%0d got=%b exp=0", i, bus.RF_WriteEn_Out);
            end
        end
    endtask

    task automatic test_wb_write();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 5'd3, 32'd2, 1'b0, 5'd0, 32'd0);
                1:       drive(1'b1, 5'd0, 32'd5, 1'b0, 5'd0, 32'd0);
                default: drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            endcase
            @(negedge clk); model_eval();
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== {exp_stall, exp_ready}) begin
                errors++;
                $display("FAIL wb_comb i=%0d got stall=%b ready=%b exp %b/%b", i, bus.Stall_Out, bus.MD_Ready_Out, exp_stall, exp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== exp_en || (exp_en && (bus.RF_WriteReg_Out !== exp_reg || bus.RF_WriteData_Out !== exp_data))) begin
                errors++;
                $display("FAIL wb_rf i=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h", i,
                         bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, exp_en, exp_reg, exp_data);
            end
        end
    endtask

    task automatic test_md_drain();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA);
                1:       drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hB);
                default: drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            endcase
            @(negedge clk); model_eval();
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== {exp_stall, exp_ready}) begin
                errors++;
                $display("FAIL drain_comb i=%0d got stall=%b ready=%b exp %b/%b", i, bus.Stall_Out, bus.MD_Ready_Out, exp_stall, exp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== exp_en || (exp_en && (bus.RF_WriteReg_Out !== exp_reg || bus.RF_WriteData_Out !== exp_data))) begin
                errors++;
                $display("FAIL drain_rf i=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h", i,
                         bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, exp_en, exp_reg, exp_data);
            end
        end
    endtask

    task automatic test_starve();
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        held;
        int          stall_cnt, stall_at;
        stall_cnt = 0; stall_at = -1; held = 1'b0;
        wr = 5'd1; wd = 32'd0;
        for (int i = 0; i < 14; i++) begin
            if (!held) begin
                wr = 5'($urandom_range(1, 31));
                wd = $urandom;
            end
            drive(1'b1, wr, wd, (i == 0), 5'd7, 32'h7);
            @(negedge clk); model_eval();
            held = bus.Stall_Out;
            if (bus.Stall_Out === 1'b1) begin
                stall_cnt++;
                if (stall_at < 0) stall_at = i;
            end
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== {exp_stall, exp_ready}) begin
                errors++;
                $display("FAIL starve_comb i=%0d got stall=%b ready=%b exp %b/%b", i, bus.Stall_Out, bus.MD_Ready_Out, exp_stall, exp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== exp_en || (exp_en && (bus.RF_WriteReg_Out !== exp_reg || bus.RF_WriteData_Out !== exp_data))) begin
                errors++;
                $display("FAIL starve_rf i=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h", i,
                         bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, exp_en, exp_reg, exp_data);
            end
        end
        checks++;
        if (stall_cnt != 1 || stall_at != STARVE_LIMIT + 1) begin
            errors++;
            $display("FAIL starve_window got cnt=%0d at=%0d exp cnt=1 at=%0d", stall_cnt, stall_at, STARVE_LIMIT + 1);
        end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 16; i++) begin
            if (i < 5)       drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'(10 + i), 32'(100 + i));
            else if (i < 9)  drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else             drive(1'b0, 5'd0, 32'd0, (i < 15), 5'(11 + i), 32'(200 + i));
            @(negedge clk); model_eval();
            if (i == 4) begin
                checks++;
                if (bus.MD_Ready_Out !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready got=%b exp=0", bus.MD_Ready_Out);
                end
            end
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== {exp_stall, exp_ready}) begin
                errors++;
                $display("FAIL full_comb i=%0d got stall=%b ready=%b exp %b/%b", i, bus.Stall_Out, bus.MD_Ready_Out, exp_stall, exp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== exp_en || (exp_en && (bus.RF_WriteReg_Out !== exp_reg || bus.RF_WriteData_Out !== exp_data))) begin
                errors++;
                $display("FAIL full_rf i=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h", i,
                         bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, exp_en, exp_reg, exp_data);
            end
        end
    endtask

    task automatic test_random();
        int live_pct;
        for (int i = 0; i < 620; i++) begin
            live_pct = ((i / 100) % 2 == 1) ? 95 : 55;
            if (i >= 600) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else drive(($urandom_range(0, 99) < live_pct), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom, ($urandom_range(0, 99) < 40), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom);
`ifdef WBA_PENDING_CHECK_EN
            bus.Query_Reg_In = 5'($urandom_range(0, 31));
`endif
            @(negedge clk); model_eval();
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== {exp_stall, exp_ready}) begin
                errors++;
                $display("FAIL rand_comb i=%0d got stall=%b ready=%b exp %b/%b", i, bus.Stall_Out, bus.MD_Ready_Out, exp_stall, exp_ready);
            end
`ifdef WBA_PENDING_CHECK_EN
            checks++;
            if (bus.Pending_Hit_Out !== exp_pend) begin
                errors++;
                $display("FAIL rand_pend i=%0d got=%b exp=%b", i, bus.Pending_Hit_Out, exp_pend);
            end
`endif
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== exp_en || (exp_en && (bus.RF_WriteReg_Out !== exp_reg || bus.RF_WriteData_Out !== exp_data))) begin
                errors++;
                $display("FAIL rand_rf i=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h", i,
                         bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, exp_en, exp_reg, exp_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            if (i < 3) drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'(15 + i), 32'(300 + i));
            else       drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            if (i == 3) begin
                #3 rst = 1'b1;
                #1;
                checks++;
                if ({bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, bus.Stall_Out, bus.MD_Ready_Out}
                    !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL midreset_vals got en=%b reg=%0d data=%h stall=%b ready=%b exp 0/0/0/0/1",
                             bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, bus.Stall_Out, bus.MD_Ready_Out);
                end
                model_clear();
                @(negedge clk) rst = 1'b0;
            end
            @(negedge clk); model_eval();
            checks++;
            if ({bus.Stall_Out, bus.MD_Ready_Out} !== {exp_stall, exp_ready}) begin
                errors++;
                $display("FAIL midreset_comb i=%0d got stall=%b ready=%b exp %b/%b", i, bus.Stall_Out, bus.MD_Ready_Out, exp_stall, exp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RF_WriteEn_Out !== exp_en || (exp_en && (bus.RF_WriteReg_Out !== exp_reg || bus.RF_WriteData_Out !== exp_data))) begin
                errors++;
                $display("FAIL midreset_rf i=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h", i,
                         bus.RF_WriteEn_Out, bus.RF_WriteReg_Out, bus.RF_WriteData_Out, exp_en, exp_reg, exp_data);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_wb_write();
        test_md_drain();
        test_starve();
        test_full_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
